// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the multi-cycle arithmetic units (multiplier now,
//   divider and MAC later).
//   - state_e   : control state encoding (IDLE / RUN / DONE)
//   - cnt_width : iteration-counter width for a given operand width
//   - CNT_W     : counter width for the default 32-bit operand width
// ----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Width needed to count 0 .. width-1; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/twos_negate.sv
// ----------------------------------------------------------------------------
// twos_negate
//   Conditional two's-complement negation: out_o = cond_i ? -in_i : in_i.
//   Ports:
//     cond_i  in  1  negate when high
//     in_i    in  W  value to pass through or negate
//     out_o   out W  result, same width as in_i (wraps like hardware)
// ----------------------------------------------------------------------------
module twos_negate #(
    parameter int W = 32
) (
    input  logic         cond_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    assign out_o = cond_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/seq_signed_mult.sv
// ----------------------------------------------------------------------------
// seq_signed_mult
//   Sign-magnitude shift-add multiplier. Operand magnitudes are multiplied as
//   unsigned over WIDTH RUN cycles, then the sign is applied once on the way
//   into the product register.
//   Ports:
//     clk      in  1        rising-edge clock
//     rst      in  1        synchronous active-high reset
//     start    in  1        request, honoured in IDLE or DONE
//     a        in  WIDTH    multiplicand, two's complement
//     b        in  WIDTH    multiplier, two's complement
//     busy     out 1        high during the WIDTH iteration cycles
//     done     out 1        one-cycle pulse when product is updated
//     product  out 2*WIDTH  signed product, registered
// ----------------------------------------------------------------------------
module seq_signed_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   mcand_ext;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   signed_result;

    // |-2^(WIDTH-1)| comes out as 2^(WIDTH-1), which is exact when read as
    // unsigned, so the most negative operand needs no special case.
    twos_negate #(.W(WIDTH)) u_mag_a (
        .cond_i (a[WIDTH-1]),
        .in_i   (a),
        .out_o  (a_mag)
    );

    twos_negate #(.W(WIDTH)) u_mag_b (
        .cond_i (b[WIDTH-1]),
        .in_i   (b),
        .out_o  (b_mag)
    );

    assign mcand_ext = {{WIDTH{1'b0}}, mcand_q};

    // Partial product for iteration cnt_q: multiplicand weighted by 2^cnt_q.
    assign acc_sum = mplier_q[0] ? (acc_q + (mcand_ext << cnt_q)) : acc_q;

    // Sign fix sees the sum including the final iteration; negating zero
    // yields zero, so a zero product is never negative.
    twos_negate #(.W(2*WIDTH)) u_sign_fix (
        .cond_i (neg_q),
        .in_i   (acc_sum),
        .out_o  (signed_result)
    );

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    product_d = signed_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    // Decoded straight from the state register: no input-to-output path.
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// ----------------------------------------------------------------------------
// tb_seq_signed_mult
//   Self-checking bench for seq_signed_mult (WIDTH = 32). Expected products
//   come from plain signed 64-bit arithmetic; expected timing comes from the
//   start/busy/done cycle rules. Inputs change and outputs are sampled on the
//   falling edge.
// ----------------------------------------------------------------------------
module tb_seq_signed_mult;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_signed_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Reference: exact signed product of two 32-bit two's-complement values.
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    // Issue one request and observe the following 40 cycles. Cycle index 1
    // is the first cycle after the accepting edge. Optionally pokes a second
    // start with other operands at cycle poke_idx (0 = never).
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input int poke_idx,
                          output int busy_cycles, output int first_done,
                          output int done_cnt, output int overlap,
                          output logic [2*W-1:0] prod);
        busy_cycles = 0;
        first_done  = -1;
        done_cnt    = 0;
        overlap     = 0;
        prod        = 'x;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        for (int idx = 1; idx <= 40; idx++) begin
            if (busy === 1'b1) busy_cycles++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = idx;
                    prod = product;
                end
            end
            start = (idx == poke_idx);
            if (idx == poke_idx) begin
                a = 32'h0000_0100;
                b = 32'h0000_0100;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd6;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0",
                     busy, done, product);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start_suppressed: busy=%b want 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [4] = '{32'd3, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [W-1:0]   tb [4] = '{32'hFFFF_FFFB, 32'h8000_0000,
                                   32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [2*W-1:0] te [4] = '{64'hFFFF_FFFF_FFFF_FFF1,
                                   64'h4000_0000_0000_0000,
                                   64'hC000_0000_8000_0000,
                                   64'h0};
        int bc, fd, dc, ov;
        logic [2*W-1:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 0, bc, fd, dc, ov, p);
            n_cmp++;
            if (bc !== 32 || ov !== 0) begin
                n_bad++;
                $display("FAIL directed_busy[%0d]: busy_cycles=%0d overlap=%0d, want 32 0",
                         i, bc, ov);
            end
            n_cmp++;
            if (fd !== 33 || dc !== 1) begin
                n_bad++;
                $display("FAIL directed_done[%0d]: done at %0d count %0d, want 33 1",
                         i, fd, dc);
            end
            n_cmp++;
            if (p !== te[i]) begin
                n_bad++;
                $display("FAIL directed_product[%0d]: got %h want %h", i, p, te[i]);
            end
        end
        // Product holds in IDLE after the operation.
        n_cmp++;
        if (product !== te[3]) begin
            n_bad++;
            $display("FAIL product_hold: got %h want %h", product, te[3]);
        end
    endtask

    task automatic test_random();
        int bc, fd, dc, ov;
        logic [2*W-1:0] p;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                2: ra = 32'hFFFF_FFFF;
                3: ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'h0;
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 0, bc, fd, dc, ov, p);
            n_cmp++;
            if (bc !== 32 || fd !== 33 || dc !== 1 || ov !== 0) begin
                n_bad++;
                $display("FAIL random_timing[%0d]: busy=%0d done_at=%0d dones=%0d ov=%0d, want 32 33 1 0",
                         i, bc, fd, dc, ov);
            end
            n_cmp++;
            if (p !== ref_mult(ra, rb)) begin
                n_bad++;
                $display("FAIL random_product[%0d]: a=%h b=%h got %h want %h",
                         i, ra, rb, p, ref_mult(ra, rb));
            end
        end
    endtask

    task automatic test_ignore_start();
        int bc, fd, dc, ov;
        logic [2*W-1:0] p;
        run_op(32'h0000_1234, 32'hFFFF_FF00, 5, bc, fd, dc, ov, p);
        n_cmp++;
        if (bc !== 32 || fd !== 33 || dc !== 1) begin
            n_bad++;
            $display("FAIL ignore_start_timing: busy=%0d done_at=%0d dones=%0d, want 32 33 1",
                     bc, fd, dc);
        end
        n_cmp++;
        if (p !== ref_mult(32'h0000_1234, 32'hFFFF_FF00)) begin
            n_bad++;
            $display("FAIL ignore_start_product: got %h want %h",
                     p, ref_mult(32'h0000_1234, 32'hFFFF_FF00));
        end
    endtask

    task automatic test_back_to_back();
        int d_at [2];
        logic [2*W-1:0] d_p [2];
        int dc = 0;
        int ov = 0;
        logic busy34 = 1'b0;
        logic [2*W-1:0] prod34 = '0;
        @(negedge clk);
        a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        a = 32'hFFFF_FFF9; b = 32'd6;
        for (int idx = 1; idx <= 80; idx++) begin
            if (busy === 1'b1 && done === 1'b1) ov++;
            if (done === 1'b1) begin
                if (dc < 2) begin
                    d_at[dc] = idx;
                    d_p[dc]  = product;
                end
                dc++;
            end
            if (idx == 34) begin
                busy34 = busy;
                prod34 = product;
            end
            if (idx == 66) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (dc !== 2 || ov !== 0) begin
            n_bad++;
            $display("FAIL b2b_done_count: dones=%0d overlap=%0d, want 2 0", dc, ov);
        end else begin
            n_cmp++;
            if (d_at[0] !== 33 || d_at[1] !== 66) begin
                n_bad++;
                $display("FAIL b2b_done_cycles: got %0d %0d want 33 66", d_at[0], d_at[1]);
            end
            n_cmp++;
            if (d_p[0] !== 64'd42 || d_p[1] !== 64'hFFFF_FFFF_FFFF_FFD6) begin
                n_bad++;
                $display("FAIL b2b_products: got %h %h want %h %h", d_p[0], d_p[1],
                         64'd42, 64'hFFFF_FFFF_FFFF_FFD6);
            end
        end
        n_cmp++;
        if (busy34 !== 1'b1 || prod34 !== 64'd42) begin
            n_bad++;
            $display("FAIL b2b_no_gap: busy=%b product=%h, want 1 %h", busy34, prod34, 64'd42);
        end
    endtask

    task automatic test_reset_abort();
        int dc = 0;
        @(negedge clk);
        a = 32'd1000; b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 1; idx <= 50; idx++) begin
            if (idx == 11) begin
                rst = 1'b0;
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
                    n_bad++;
                    $display("FAIL reset_abort_state: busy=%b done=%b product=%h, want 0 0 0",
                             busy, done, product);
                end
            end
            if (done === 1'b1) dc++;
            if (idx == 10) rst = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (dc !== 0) begin
            n_bad++;
            $display("FAIL reset_abort_no_done: dones=%0d want 0", dc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_signed_mult.md
# seq_signed_mult

Multi-cycle signed multiplier with a start/busy/done handshake. It sits downstream of the sign-extension stage and accepts two WIDTH-bit two's-complement operands, normally sign-extended immediates or register values. It produces the full 2·WIDTH-bit signed product after a fixed WIDTH-cycle shift-add sequence. It serves the execute stage for MULT-class instructions, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits; product is 2·WIDTH.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only when the block is idle or in the done cycle.
- `a`  in  WIDTH  multiplicand, two's complement.
- `b`  in  WIDTH  multiplier, two's complement.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `product` is updated.
- `product`  out  2·WIDTH  signed result, registered.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: one-cycle completion state.
- Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→DONE when iteration count = WIDTH−1 at the edge.
  - DONE→RUN when `start`=1; otherwise DONE→IDLE.
- Accept (IDLE or DONE with `start`=1):
  - Latch the magnitudes `|a|`, `|b|` as WIDTH-bit unsigned values. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits without overflow.
  - Latch the result sign `neg = a[WIDTH−1] ^ b[WIDTH−1]`.
  - Clear the 2·WIDTH accumulator and the iteration counter.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted left by the iteration index, into the accumulator.
  - Shift the multiplier right by 1.
  - Increment the counter.
  - Exactly WIDTH RUN cycles occur.
- Entering DONE:
  - `product` ← `neg` ? −acc : acc, in 2·WIDTH-bit two's complement.
  - A zero result is never negative: −0 = 0.
- `start` during RUN is ignored and not queued. `a` and `b` are don't-care except in the accept cycle.
- `product` holds its value until the next entry into DONE. It is not cleared on a new start.
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, counter=0, accumulator=0.
- `rst` during RUN or DONE aborts the operation on that edge. No `done` is produced, and `product` returns to 0.
- `rst` and `start` high together: reset wins.
- No overflow is possible; the 2·WIDTH result is exact for all operand pairs.

## Timing
- Define `start`=1 with acceptance in cycle n (n is the cycle ending at the accepting edge).
- `busy`=1 in cycles n+1 … n+WIDTH (WIDTH cycles).
- `done`=1 and the new `product` visible in cycle n+WIDTH+1.
- Latency is WIDTH+1 cycles from start to done, and throughput is one multiply per WIDTH+1 cycles.
- Back-to-back: `start`=1 during the DONE cycle gives `busy`=1 in the next cycle, with no idle gap.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mult_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - counter width `CNT_W = $clog2(WIDTH)`.
  - Later divider and MAC units reuse these constants.
- One natural sub-module, `twos_negate`, parameterised by width, combinational `out = cond ? ~in+1 : in`.
  - Used three times: magnitude of `a`, magnitude of `b`, and the final sign fix.
- Datapath and FSM live in a single module; no further hierarchy.

## Test plan
- `a`=3, `b`=−5, one start → `busy` high 32 cycles, `done` pulses once in cycle n+33, `product`=64'hFFFF_FFFF_FFFF_FFF1 (−15).
- `a`=32'h8000_0000, `b`=32'h8000_0000 → `product`=64'h4000_0000_0000_0000.
- `a`=32'h8000_0000, `b`=32'h7FFF_FFFF → `product`=64'hC000_0000_8000_0000.
- `a`=0, `b`=−1 → `product`=0.
- `start` pulsed again mid-RUN with different operands → ignored; result of the first operands only; one `done`.
- `start` held high continuously with 7×6 then −7×6 → `done` pulses in cycles n+33 and n+66, products 42 then 64'hFFFF_FFFF_FFFF_FFD6.
- `rst` asserted in RUN cycle 10 → next cycle `busy`=0, `done`=0, `product`=0; no `done` follows.
